// File: rtl/udma_ch_grant_arb.sv
// Round-robin grant arbiter for the uDMA channel address generators, feeding a single
// registered transaction stage toward the L2 port.
module udma_ch_grant_arb #(
   parameter int N_CH           = 4,
   parameter int L2_AWIDTH_NOAL = 18
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic [N_CH-1:0]                ch_req_i,
   input  logic [N_CH*L2_AWIDTH_NOAL-1:0] ch_addr_i,
   input  logic [N_CH*2-1:0]              ch_datasize_i,
   output logic [N_CH-1:0]                ch_gnt_o,
   output logic                           not_stall_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [L2_AWIDTH_NOAL-1:0]      out_addr_o,
   output logic [1:0]                     out_datasize_o,
   output logic [$clog2(N_CH)-1:0]        out_ch_id_o
);

   localparam int CH_ID_W = $clog2(N_CH);
   localparam int AW      = L2_AWIDTH_NOAL;

   logic               out_valid_q, out_valid_d;
   logic [AW-1:0]      out_addr_q, out_addr_d;
   logic [1:0]         out_datasize_q, out_datasize_d;
   logic [CH_ID_W-1:0] out_ch_id_q, out_ch_id_d;
   logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [N_CH-1:0]    gnt;
   logic               found;
   logic [CH_ID_W-1:0] win_id;
   logic [CH_ID_W:0]   sum;
   logic [CH_ID_W-1:0] cand;

   // Output handshake: a transaction moves to L2 when out_valid_o && out_ready_i; while
   // valid is high and ready is low the payload holds and no channel is granted.
   assign not_stall_o = !out_valid_q || out_ready_i;

   always_comb begin
      gnt    = '0;
      found  = 1'b0;
      win_id = '0;
      sum    = '0;
      cand   = '0;
      if (not_stall_o) begin
         for (int i = 0; i < N_CH; i++) begin
            sum = {1'b0, rr_ptr_q} + (CH_ID_W+1)'(i);
            if (sum >= (CH_ID_W+1)'(N_CH)) sum = sum - (CH_ID_W+1)'(N_CH);
            cand = sum[CH_ID_W-1:0];
            if (!found && ch_req_i[cand]) begin
               found     = 1'b1;
               gnt[cand] = 1'b1;
               win_id    = cand;
            end
         end
      end
   end

   always_comb begin
      out_valid_d    = out_valid_q;
      out_addr_d     = out_addr_q;
      out_datasize_d = out_datasize_q;
      out_ch_id_d    = out_ch_id_q;
      rr_ptr_d       = rr_ptr_q;
      if (found) begin
         out_valid_d    = 1'b1;
         out_addr_d     = ch_addr_i[int'(win_id)*AW +: AW];
         out_datasize_d = ch_datasize_i[int'(win_id)*2 +: 2];
         out_ch_id_d    = win_id;
         rr_ptr_d       = (win_id == CH_ID_W'(N_CH-1)) ? '0 : win_id + 1'b1;
      end else if (out_ready_i) begin
         // Drained with nothing new: payload keeps its last value.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         out_valid_q    <= 1'b0;
         out_addr_q     <= '0;
         out_datasize_q <= '0;
         out_ch_id_q    <= '0;
         rr_ptr_q       <= '0;
      end else begin
         out_valid_q    <= out_valid_d;
         out_addr_q     <= out_addr_d;
         out_datasize_q <= out_datasize_d;
         out_ch_id_q    <= out_ch_id_d;
         rr_ptr_q       <= rr_ptr_d;
      end
   end

   assign ch_gnt_o       = gnt;
   assign out_valid_o    = out_valid_q;
   assign out_addr_o     = out_addr_q;
   assign out_datasize_o = out_datasize_q;
   assign out_ch_id_o    = out_ch_id_q;

endmodule

// File: tb/tb_udma_ch_grant_arb.sv
// Directed bench for udma_ch_grant_arb: reset, single channel, round-robin order,
// backpressure, wrap/skip, drain and asynchronous reset while stalled.
module tb_udma_ch_grant_arb;

   localparam int N_CH = 4;
   localparam int AW   = 18;

   logic                   clk_i = 1'b0;
   logic                   rstn_i;
   logic [N_CH-1:0]        ch_req_i;
   logic [N_CH-1:0][AW-1:0] ch_addr;
   logic [N_CH-1:0][1:0]   ch_ds;
   logic [N_CH-1:0]        ch_gnt_o;
   logic                   not_stall_o;
   logic                   out_valid_o;
   logic                   out_ready_i;
   logic [AW-1:0]          out_addr_o;
   logic [1:0]             out_datasize_o;
   logic [1:0]             out_ch_id_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] exp_q[$];

   udma_ch_grant_arb #(.N_CH(N_CH), .L2_AWIDTH_NOAL(AW)) dut (
      .clk_i          (clk_i),
      .rstn_i         (rstn_i),
      .ch_req_i       (ch_req_i),
      .ch_addr_i      (ch_addr),
      .ch_datasize_i  (ch_ds),
      .ch_gnt_o       (ch_gnt_o),
      .not_stall_o    (not_stall_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_addr_o     (out_addr_o),
      .out_datasize_o (out_datasize_o),
      .out_ch_id_o    (out_ch_id_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      cycle();
      rstn_i = 1'b1;
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [AW-1:0] a,
                            input logic [1:0] ds, input logic [1:0] id);
      check({tag, "_valid"}, 32'(out_valid_o), 32'(v));
      check({tag, "_addr"},  32'(out_addr_o), 32'(a));
      check({tag, "_ds"},    32'(out_datasize_o), 32'(ds));
      check({tag, "_id"},    32'(out_ch_id_o), 32'(id));
   endtask

   initial begin
      rstn_i      = 1'b0;
      ch_req_i    = '0;
      out_ready_i = 1'b1;
      ch_addr[0] = 18'h100; ch_ds[0] = 2'b10;
      ch_addr[1] = 18'h110; ch_ds[1] = 2'b01;
      ch_addr[2] = 18'h2A0; ch_ds[2] = 2'b00;
      ch_addr[3] = 18'h330; ch_ds[3] = 2'b11;

      // reset state
      #12;
      check_out("rst", 1'b0, '0, 2'b00, 2'd0);
      check("rst_not_stall", 32'(not_stall_o), 32'd1);
      check("rst_gnt", 32'(ch_gnt_o), 32'd0);
      cycle();
      rstn_i = 1'b1;
      #1;

      // T1 single channel
      ch_req_i = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t1_gnt", 32'(ch_gnt_o), 32'h1);
         cycle();
         check_out("t1", 1'b1, 18'h100, 2'b10, 2'd0);
      end

      // T2 round-robin from a fresh pointer
      ch_req_i = '0;
      do_reset();
      ch_req_i = 4'b1111;
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int c = 0; c < 5; c++) begin
         logic [3:0] e;
         logic [1:0] id;
         e  = exp_q.pop_front();
         id = (e == 4'b0001) ? 2'd0 : (e == 4'b0010) ? 2'd1 : (e == 4'b0100) ? 2'd2 : 2'd3;
         #1;
         check("t2_gnt", 32'(ch_gnt_o), 32'(e));
         cycle();
         check("t2_id", 32'(out_ch_id_o), 32'(id));
         check("t2_valid", 32'(out_valid_o), 32'd1);
      end

      // T3 backpressure: pointer is 1, only ch2 requests
      ch_req_i = 4'b0100;
      #1;
      check("t3_gnt2", 32'(ch_gnt_o), 32'b0100);
      cycle();
      out_ready_i = 1'b0;
      ch_req_i    = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("t3_not_stall", 32'(not_stall_o), 32'd0);
         check("t3_gnt_blocked", 32'(ch_gnt_o), 32'd0);
         check_out("t3_hold", 1'b1, 18'h2A0, 2'b00, 2'd2);
         cycle();
      end
      check_out("t3_hold_end", 1'b1, 18'h2A0, 2'b00, 2'd2);
      out_ready_i = 1'b1;
      #1;
      check("t3_not_stall_rel", 32'(not_stall_o), 32'd1);
      check("t3_gnt3", 32'(ch_gnt_o), 32'b1000);
      cycle();
      check_out("t3_ch3", 1'b1, 18'h330, 2'b11, 2'd3);

      // T4 wrap/skip: grant ch2 to put the pointer at 3
      ch_req_i = 4'b0100;
      cycle();
      ch_req_i = 4'b0101;
      exp_q = '{4'b0001, 4'b0100, 4'b0001};
      for (int c = 0; c < 3; c++) begin
         logic [3:0] e;
         e = exp_q.pop_front();
         #1;
         check("t4_gnt", 32'(ch_gnt_o), 32'(e));
         cycle();
         check("t4_id", 32'(out_ch_id_o), (e == 4'b0001) ? 32'd0 : 32'd2);
      end

      // T5 drain: pointer is 1
      ch_req_i = 4'b0010;
      #1;
      check("t5_gnt", 32'(ch_gnt_o), 32'b0010);
      cycle();
      ch_req_i = '0;
      #1;
      check("t5_gnt_idle", 32'(ch_gnt_o), 32'd0);
      check_out("t5_one", 1'b1, 18'h110, 2'b01, 2'd1);
      cycle();
      check_out("t5_drained", 1'b0, 18'h110, 2'b01, 2'd1);
      cycle();
      check("t5_still_idle", 32'(out_valid_o), 32'd0);
      ch_req_i = 4'b1111;
      #1;
      check("t5_ptr_kept", 32'(ch_gnt_o), 32'b0100);
      cycle();

      // T6 asynchronous reset while stalled
      ch_req_i    = 4'b0001;
      out_ready_i = 1'b1;
      cycle();
      ch_req_i    = '0;
      out_ready_i = 1'b0;
      #2;
      check("t6_pre_valid", 32'(out_valid_o), 32'd1);
      rstn_i = 1'b0;
      #1;
      check_out("t6_rst", 1'b0, '0, 2'b00, 2'd0);
      check("t6_not_stall", 32'(not_stall_o), 32'd1);
      cycle();
      rstn_i      = 1'b1;
      out_ready_i = 1'b1;
      ch_req_i    = 4'b1111;
      #1;
      check("t6_first_gnt", 32'(ch_gnt_o), 32'b0001);
      cycle();
      check_out("t6_after", 1'b1, 18'h100, 2'b10, 2'd0);

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
